accum_writeback_ctrl: RTL and testbench

Drains a block of accumulator rows into the unified buffer after a matrix-multiply tile completes. The block sequences accumulator reads and applies the requantization datapath: rounding right shift, optional ReLU and signed 16-bit saturation. It then issues unified-buffer write requests under a request/grant handshake, so the write port can be shared with host loads. It sits between the accumulator (addressed and read by this block) and the unified buffer write port, and is started by the control unit.

---
 rtl/accum_writeback_ctrl.sv | 119 +++++++++++
 tb/tb_accum_writeback_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/accum_writeback_ctrl.sv
// accum_writeback_ctrl: drains accumulator rows through requantization into the unified buffer
module accum_writeback_ctrl #(
  parameter int ACC_RD_LAT = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LANES      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [7:0]             num_rows_i,
  input  logic [6:0]             accum_base_i,
  input  logic [11:0]            ub_base_i,
  input  logic [4:0]             shift_i,
  input  logic                   relu_i,
  output logic                   accum_rd_en_o,
  output logic [6:0]             accum_addr_rd_o,
  input  logic [LANES-1:0][31:0] accum_data_i,
  output logic                   ub_write_o,
  output logic [11:0]            ub_addr_wr_o,
  output logic [LANES-1:0][15:0] ub_data_o,
  input  logic                   ub_grant_i,
  output logic                   busy_o,
  output logic                   done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state_q, state_d;
  logic [7:0] num_q, issued_q;
  logic [6:0] rd_addr_q;
  logic [11:0] wr_addr_q;
  logic [4:0] shift_q;
  logic relu_q;
  logic [ACC_RD_LAT-1:0] pipe_q;
  logic [LANES-1:0][15:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, in_flight;
  logic push, pop;
  logic [LANES-1:0][15:0] rq_row;

  function automatic logic [15:0] rq(input logic [31:0] a, input logic [4:0] s, input logic r);
    logic signed [32:0] x, v;
    x = {a[31], a};
    v = s == 5'd0 ? x : (x + (33'sd1 <<< (s - 5'd1))) >>> s;
    v = r && v < 0 ? '0 : v;
    return v > 33'sd32767 ? 16'h7fff : v < -33'sd32768 ? 16'h8000 : v[15:0];
  endfunction

  assign in_flight       = CW'($countones(pipe_q));
  assign push            = pipe_q[ACC_RD_LAT-1];
  assign pop             = cnt_q != '0 && ub_grant_i;
  assign accum_rd_en_o   = state_q == RUN && int'(cnt_q) + int'(in_flight) - int'(pop) < FIFO_DEPTH;
  assign accum_addr_rd_o = accum_rd_en_o ? rd_addr_q : '0;
  assign ub_write_o      = cnt_q != '0;
  assign ub_addr_wr_o    = ub_write_o ? wr_addr_q : '0;
  assign ub_data_o       = ub_write_o ? fifo_q[rp_q] : '0;
  assign busy_o          = state_q == RUN || state_q == DRAIN;
  assign done_o          = state_q == DONE;

  // requantize each lane of the returning row before it lands in the FIFO
  always_comb begin
    rq_row = '0;
    for (int l = 0; l < LANES; l++) rq_row[l] = rq(accum_data_i[l], shift_q, relu_q);
  end

  // sequencing: zero-row jobs skip straight to completion; drain ends once the last row is granted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = num_rows_i == 8'd0 ? DONE : RUN;
      RUN:     if (accum_rd_en_o && issued_q == num_q - 8'd1) state_d = DRAIN;
      DRAIN:   if (in_flight == '0 && (cnt_q == '0 || (cnt_q == CW'(1) && pop))) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // job registers, read/write address counters, in-flight pipe and FIFO occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      num_q     <= '0;
      issued_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      pipe_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= ACC_RD_LAT'({pipe_q, accum_rd_en_o});
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      if (state_q == IDLE && start_i) begin
        num_q     <= num_rows_i;
        issued_q  <= '0;
        rd_addr_q <= accum_base_i;
        wr_addr_q <= ub_base_i;
        shift_q   <= shift_i;
        relu_q    <= relu_i;
      end
      if (accum_rd_en_o) begin
        issued_q  <= issued_q + 8'd1;
        rd_addr_q <= rd_addr_q + 7'd1;
      end
      if (push) wp_q <= wp_q == PW'(FIFO_DEPTH - 1) ? '0 : wp_q + PW'(1);
      if (pop) begin
        rp_q      <= rp_q == PW'(FIFO_DEPTH - 1) ? '0 : rp_q + PW'(1);
        wr_addr_q <= wr_addr_q + 12'd1;
      end
    end
  end

  // FIFO storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wp_q] <= rq_row;
  end
endmodule

// File: tb/tb_accum_writeback_ctrl.sv
// tb_accum_writeback_ctrl: table-driven and randomized checks of the accumulator writeback controller
module tb_accum_writeback_ctrl;
  localparam int LAT   = 1;
  localparam int LANES = 32;

  logic clk_i, rst_i, start_i, relu_i, ub_grant_i;
  logic [7:0] num_rows_i;
  logic [6:0] accum_base_i;
  logic [11:0] ub_base_i;
  logic [4:0] shift_i;
  logic accum_rd_en_o, ub_write_o, busy_o, done_o;
  logic [6:0] accum_addr_rd_o;
  logic [11:0] ub_addr_wr_o;
  logic [LANES-1:0][31:0] accum_data_i;
  logic [LANES-1:0][15:0] ub_data_o;

  accum_writeback_ctrl #(.ACC_RD_LAT(LAT), .FIFO_DEPTH(4), .LANES(LANES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_rows_i(num_rows_i),
    .accum_base_i(accum_base_i), .ub_base_i(ub_base_i), .shift_i(shift_i), .relu_i(relu_i),
    .accum_rd_en_o(accum_rd_en_o), .accum_addr_rd_o(accum_addr_rd_o), .accum_data_i(accum_data_i),
    .ub_write_o(ub_write_o), .ub_addr_wr_o(ub_addr_wr_o), .ub_data_o(ub_data_o),
    .ub_grant_i(ub_grant_i), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // accumulator memory model with fixed read latency; junk on the bus when nothing is valid
  logic [LANES-1:0][31:0] acc_mem [128];
  logic [6:0] ra [LAT];
  logic rv [LAT];
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) rv[i] <= 1'b0;
    end else begin
      rv[0] <= accum_rd_en_o;
      ra[0] <= accum_addr_rd_o;
      for (int i = 1; i < LAT; i++) begin
        rv[i] <= rv[i-1];
        ra[i] <= ra[i-1];
      end
    end
  end
  assign accum_data_i = rv[LAT-1] ? acc_mem[ra[LAT-1]] : {LANES{32'hdeadbeef}};

  // monitor: log reads, accepted writes and done pulses; check hold-while-ungranted and credits
  logic [6:0] rd_q [$];
  logic [11:0] wa_q [$];
  logic [LANES-1:0][15:0] wd_q [$];
  int done_cnt = 0;
  bit pend = 0;
  logic [11:0] pa;
  logic [LANES-1:0][15:0] pd;
  always @(negedge clk_i) begin
    if (pend) chk("hold_while_ungranted", {ub_write_o, ub_addr_wr_o, ub_data_o}, {1'b1, pa, pd});
    pend = ub_write_o && !ub_grant_i && !rst_i;
    pa = ub_addr_wr_o;
    pd = ub_data_o;
    if (busy_o) chk("credit_limit", (rd_q.size() - wa_q.size()) <= 4, 1'b1);
    if (accum_rd_en_o) rd_q.push_back(accum_addr_rd_o);
    if (ub_write_o && ub_grant_i) begin
      wa_q.push_back(ub_addr_wr_o);
      wd_q.push_back(ub_data_o);
    end
    if (done_o) done_cnt++;
  end

  // reference requantization with plain integer arithmetic and floor division
  function automatic logic [15:0] ref_rq(input logic [31:0] raw, input int sh, input bit rl);
    longint a, d, x, q;
    a = longint'($signed(raw));
    if (sh == 0) q = a;
    else begin
      d = longint'(1) << sh;
      x = a + d / 2;
      q = (x - (((x % d) + d) % d)) / d;
    end
    if (rl && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  function automatic logic [LANES-1:0][15:0] exp_row(input int row, input int sh, input bit rl);
    logic [LANES-1:0][15:0] r;
    for (int l = 0; l < LANES; l++) r[l] = ref_rq(acc_mem[row][l], sh, rl);
    return r;
  endfunction

  function automatic logic gnt(input int mode, input int cyc);
    return mode == 0 ? 1'b1 : mode == 2 ? !(cyc >= 4 && cyc < 12) : ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic [639:0] all_outs();
    return {accum_rd_en_o, accum_addr_rd_o, ub_write_o, ub_addr_wr_o, ub_data_o, busy_o, done_o};
  endfunction

  task automatic run_job(input int ab, input int ub, input int n, input int sh, input bit rl,
                         input int mode, input bit dup);
    int done_at, first_wr;
    done_at = -1;
    first_wr = -1;
    @(posedge clk_i); #1;
    rd_q.delete(); wa_q.delete(); wd_q.delete(); done_cnt = 0;
    start_i = 1'b1; num_rows_i = 8'(n); accum_base_i = 7'(ab); ub_base_i = 12'(ub);
    shift_i = 5'(sh); relu_i = rl; ub_grant_i = gnt(mode, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk_i); #1;
        start_i = dup && cyc == 3;
        if (cyc == 1) begin
          num_rows_i = 8'($urandom_range(1, 100)); accum_base_i = 7'($urandom);
          ub_base_i = 12'($urandom); shift_i = 5'($urandom); relu_i = 1'($urandom);
        end
        ub_grant_i = gnt(mode, cyc);
      end
      @(negedge clk_i);
      if (cyc == 1) chk("busy_after_start", busy_o, n != 0);
      if (ub_write_o && first_wr < 0) first_wr = cyc;
      if (done_o) begin
        done_at = cyc;
        chk("busy_at_done", busy_o, 1'b0);
        break;
      end
    end
    if (done_at < 0) chk("done_timeout", 1'b0, 1'b1);
    start_i = 1'b0;
    ub_grant_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("done_count", done_cnt, 1);
    if (mode == 0) begin
      chk("done_cycle", done_at, n == 0 ? 1 : n + LAT + 2);
      if (n > 0) chk("first_write_cycle", first_wr, LAT + 2);
    end
    chk("read_count", rd_q.size(), n);
    chk("write_count", wa_q.size(), n);
    for (int k = 0; k < n && k < rd_q.size(); k++) chk("read_addr", rd_q[k], (ab + k) % 128);
    for (int k = 0; k < n && k < wa_q.size(); k++) begin
      chk("write_addr", wa_q[k], (ub + k) % 4096);
      chk("write_data", wd_q[k], exp_row((ab + k) % 128, sh, rl));
    end
  endtask

  typedef struct {logic [31:0] acc; int sh; bit rl; logic [15:0] exp;} rq_vec_t;
  typedef struct {int ab; int ub; int n; int sh; bit rl; int mode; bit dup; bit basic;} job_t;

  initial begin
    rq_vec_t rqv [8];
    job_t jobs [7];
    logic [15:0] bv;
    int bvals [4];
    rqv = '{
      '{32'd24,        4, 1'b0, 16'h0002},
      '{32'hffffffe8,  4, 1'b0, 16'hffff},
      '{32'h7fffffff,  4, 1'b0, 16'h7fff},
      '{32'h80000000,  4, 1'b0, 16'h8000},
      '{32'hffffffe8,  4, 1'b1, 16'h0000},
      '{32'h00012345,  0, 1'b0, 16'h7fff},
      '{32'hfffffffd,  1, 1'b0, 16'hffff},
      '{32'h7fffffff, 31, 1'b0, 16'h0001}
    };
    jobs = '{
      '{5,   100,  4,   0, 1'b0, 0, 1'b0, 1'b1},
      '{126, 4094, 4,   3, 1'b0, 0, 1'b0, 1'b0},
      '{20,  300,  10,  2, 1'b1, 2, 1'b0, 1'b0},
      '{0,   0,    0,   0, 1'b0, 0, 1'b0, 1'b0},
      '{40,  1000, 6,   5, 1'b0, 0, 1'b1, 1'b0},
      '{0,   50,   128, 8, 1'b0, 1, 1'b0, 1'b0},
      '{100, 4000, 1,   0, 1'b1, 0, 1'b0, 1'b0}
    };
    bvals = '{1, -2, 3, -4};
    for (int r = 0; r < 128; r++)
      for (int l = 0; l < LANES; l++)
        acc_mem[r][l] = $urandom_range(0, 1) ? 32'($urandom) : 32'(int'($urandom_range(0, 200000)) - 100000);
    rst_i = 1'b1; start_i = 1'b0; num_rows_i = '0; accum_base_i = '0; ub_base_i = '0;
    shift_i = '0; relu_i = 1'b0; ub_grant_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_state", all_outs(), '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < LANES; l++) acc_mem[10 + i][l] = rqv[i].acc;
      run_job(10 + i, 200 + i, 1, rqv[i].sh, rqv[i].rl, 0, 1'b0);
      chk("rq_table", wd_q.size() > 0 ? wd_q[0][0] : ~rqv[i].exp, rqv[i].exp);
    end

    for (int j = 0; j < 7; j++) begin
      if (jobs[j].basic)
        for (int k = 0; k < 4; k++)
          for (int l = 0; l < LANES; l++) acc_mem[jobs[j].ab + k][l] = 32'(bvals[k]);
      run_job(jobs[j].ab, jobs[j].ub, jobs[j].n, jobs[j].sh, jobs[j].rl, jobs[j].mode, jobs[j].dup);
      if (jobs[j].basic)
        for (int k = 0; k < 4 && k < wd_q.size(); k++) begin
          bv = 16'(bvals[k]);
          chk("basic_data", wd_q[k], {LANES{bv}});
        end
    end

    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 127), $urandom_range(0, 4095), $urandom_range(1, 40),
              $urandom_range(0, 31), 1'($urandom), 1, 1'b0);

    @(posedge clk_i); #1;
    rd_q.delete(); wa_q.delete(); wd_q.delete(); done_cnt = 0;
    start_i = 1'b1; num_rows_i = 8'd8; accum_base_i = 7'd60; ub_base_i = 12'd700;
    shift_i = 5'd2; relu_i = 1'b0; ub_grant_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 50 && wa_q.size() < 3; i++) @(negedge clk_i);
    chk("reset_setup_writes", wa_q.size() >= 3, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_mid_run_outputs", all_outs(), '0);
    rd_q.delete(); wa_q.delete(); wd_q.delete(); done_cnt = 0;
    repeat (10) @(negedge clk_i);
    chk("reset_no_reads", rd_q.size(), 0);
    chk("reset_no_writes", wa_q.size(), 0);
    chk("reset_no_done", done_cnt, 0);
    run_job(60, 700, 8, 2, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
